// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core's pipeline control logic.
//   dm_state_t     : data-memory wait FSM states
//   DM_TIMEOUT_DEF : default number of DM_WAIT cycles before dm_err is raised
//   pipe_ctl_t     : the eight per-register hold/bubble controls as one bundle
package core_ctrl_pkg;

  typedef enum logic [0:0] {
    DM_IDLE = 1'b0,
    DM_WAIT = 1'b1
  } dm_state_t;

  localparam int unsigned DM_TIMEOUT_DEF = 1024;

  typedef struct packed {
    logic pc_stall;
    logic pc_sel_br;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_stall;
  } pipe_ctl_t;

endpackage

// File: rtl/dm_wait_fsm.sv
// Tracks the outstanding data-memory transaction.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   mem_req_i     : MEM stage holds a load/store
//   dm_done_i     : transaction complete (single-cycle pulse)
//   mem_hold_o    : back of the pipeline must freeze this cycle (combinational)
//   dm_err_o      : sticky timeout flag, set after DM_TIMEOUT cycles in DM_WAIT
module dm_wait_fsm
  import core_ctrl_pkg::*;
#(
  parameter int unsigned DM_TIMEOUT = DM_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mem_req_i,
  input  logic dm_done_i,
  output logic mem_hold_o,
  output logic dm_err_o
);

  localparam int unsigned CntW = (DM_TIMEOUT > 1) ? $clog2(DM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DM_TIMEOUT - 1);

  dm_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            mem_hold;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    err_d    = err_q;
    mem_hold = 1'b0;
    unique case (state_q)
      DM_IDLE: begin
        // dm_done together with mem_req is a zero-wait access: no state change.
        mem_hold = mem_req_i && !dm_done_i;
        if (mem_hold) state_d = DM_WAIT;
      end
      DM_WAIT: begin
        // mem_req is ignored here; only dm_done ends the wait.
        mem_hold = !dm_done_i;
        if (dm_done_i) begin
          state_d = DM_IDLE;
        end else if (cnt_q == CntMax) begin
          // Saturate and keep stalling; the error is only reported.
          err_d = 1'b1;
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_hold_o = mem_hold;
  assign dm_err_o   = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   mem_req_i       : MEM stage holds a load/store
//   dm_done_i       : data-memory transaction complete pulse
//   if_busy_i       : fetch outstanding
//   if_valid_i      : fetch word available (held until IF/ID accepts it)
//   ld_use_i        : load-use hazard in ID
//   br_taken_i      : branch/jump taken in EX
//   pc_stall_o .. memwb_stall_o : per-register hold/bubble controls
//   dm_err_o        : sticky data-memory timeout flag
module pipe_hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned DM_TIMEOUT = DM_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mem_req_i,
  input  logic dm_done_i,
  input  logic if_busy_i,
  input  logic if_valid_i,
  input  logic ld_use_i,
  input  logic br_taken_i,
  output logic pc_stall_o,
  output logic pc_sel_br_o,
  output logic ifid_stall_o,
  output logic ifid_flush_o,
  output logic idex_stall_o,
  output logic idex_flush_o,
  output logic exmem_stall_o,
  output logic memwb_stall_o,
  output logic dm_err_o
);

  logic      mem_hold;
  logic      br, lu, ifh;
  logic      squash_pend_q, squash_pend_d;
  pipe_ctl_t ctl;

  dm_wait_fsm #(
    .DM_TIMEOUT(DM_TIMEOUT)
  ) u_dm_wait_fsm (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .mem_req_i (mem_req_i),
    .dm_done_i (dm_done_i),
    .mem_hold_o(mem_hold),
    .dm_err_o  (dm_err_o)
  );

  // A memory wait defers the redirect; a redirect kills the ID instruction,
  // so it takes priority over load-use.
  assign br  = br_taken_i && !mem_hold;
  assign lu  = ld_use_i && !mem_hold && !br;
  assign ifh = if_busy_i && !if_valid_i;

  always_comb begin
    ctl             = '0;
    // A redirect always loads the PC, even with a fetch outstanding.
    ctl.pc_stall    = mem_hold | lu | (ifh & !br);
    ctl.pc_sel_br   = br;
    ctl.ifid_stall  = mem_hold | lu;
    ctl.ifid_flush  = !mem_hold & !lu & (br | ifh | (if_valid_i & squash_pend_q));
    ctl.idex_stall  = mem_hold;
    ctl.idex_flush  = br | lu;
    // All back stages freeze together; repeating the WB write is harmless.
    ctl.exmem_stall = mem_hold;
    ctl.memwb_stall = mem_hold;
  end

  // The word still in flight when a redirect happens belongs to the old PC
  // and must be bubbled when it arrives. Set wins over clear.
  always_comb begin
    squash_pend_d = squash_pend_q;
    if (br && ifh) begin
      squash_pend_d = 1'b1;
    end else if (if_valid_i && !ctl.ifid_stall) begin
      squash_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      squash_pend_q <= 1'b0;
    end else begin
      squash_pend_q <= squash_pend_d;
    end
  end

  assign pc_stall_o    = ctl.pc_stall;
  assign pc_sel_br_o   = ctl.pc_sel_br;
  assign ifid_stall_o  = ctl.ifid_stall;
  assign ifid_flush_o  = ctl.ifid_flush;
  assign idex_stall_o  = ctl.idex_stall;
  assign idex_flush_o  = ctl.idex_flush;
  assign exmem_stall_o = ctl.exmem_stall;
  assign memwb_stall_o = ctl.memwb_stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_req = 1'b0, dm_done = 1'b0, if_busy = 1'b0, if_valid = 1'b0;
  logic ld_use = 1'b0, br_taken = 1'b0;
  logic pc_stall, pc_sel_br, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, memwb_stall, dm_err;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .DM_TIMEOUT(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_req_i    (mem_req),
    .dm_done_i    (dm_done),
    .if_busy_i    (if_busy),
    .if_valid_i   (if_valid),
    .ld_use_i     (ld_use),
    .br_taken_i   (br_taken),
    .pc_stall_o   (pc_stall),
    .pc_sel_br_o  (pc_sel_br),
    .ifid_stall_o (ifid_stall),
    .ifid_flush_o (ifid_flush),
    .idex_stall_o (idex_stall),
    .idex_flush_o (idex_flush),
    .exmem_stall_o(exmem_stall),
    .memwb_stall_o(memwb_stall),
    .dm_err_o     (dm_err)
  );

  // {pc_stall, pc_sel_br, ifid_stall, ifid_flush, idex_stall, idex_flush,
  //  exmem_stall, memwb_stall, dm_err}
  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [8:0] dut_vec();
    return {pc_stall, pc_sel_br, ifid_stall, ifid_flush, idex_stall, idex_flush,
            exmem_stall, memwb_stall, dm_err};
  endfunction

  task automatic check(input string tag, input logic [8:0] act, input logic [8:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, dut_vec(), e.v);
      end
    end
  end

  // Reference model: memory wait as "waiting + cycles spent", sticky error,
  // and a pending-squash flag for a fetch word orphaned by a redirect.
  bit m_wait;
  int m_cycles;
  bit m_err;
  bit m_sq;

  task automatic model_reset();
    m_wait = 0; m_cycles = 0; m_err = 0; m_sq = 0;
  endtask

  task automatic drive(input string tag, input bit req, input bit done, input bit busy,
                       input bit valid, input bit ld, input bit bt);
    bit   hold, b, l, fh;
    bit   ps, ist;
    exp_t e;
    @(posedge clk);
    #1;
    mem_req = req; dm_done = done; if_busy = busy; if_valid = valid;
    ld_use = ld; br_taken = bt;
    hold = m_wait ? !done : (req && !done);
    b    = bt && !hold;
    l    = ld && !hold && !b;
    fh   = busy && !valid;
    ps   = hold || l || (fh && !b);
    ist  = hold || l;
    e.v  = {ps, b, ist, (!hold && !l && (b || fh || (valid && m_sq))),
            hold, (b || l), hold, hold, m_err};
    e.tag = tag;
    exp_q.push_back(e);
    // Advance the model to the next edge.
    if (b && fh) m_sq = 1;
    else if (valid && !ist) m_sq = 0;
    if (m_wait) begin
      if (done) begin
        m_wait = 0; m_cycles = 0;
      end else begin
        m_cycles++;
        if (m_cycles >= int'(TO)) m_err = 1;
      end
    end else if (req && !done) begin
      m_wait = 1; m_cycles = 0;
    end
  endtask

  // Reset is asserted between edges with inputs dropped; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 0;
    mem_req = 0; dm_done = 0; if_busy = 0; if_valid = 0; ld_use = 0; br_taken = 0;
    #1;
    check(tag, dut_vec(), 9'b0);
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_state", dut_vec(), 9'b0);
    #20;
    @(negedge clk);
    rst_n = 1;

    // Memory wait, dm_done in cycle 4.
    for (int i = 0; i < 4; i++) drive("mem_wait", 1, i == 3, 0, 0, 0, 0);
    drive("mem_release", 0, 0, 0, 0, 0, 0);
    // Zero-wait access.
    drive("zero_wait", 1, 1, 0, 0, 0, 0);
    drive("idle", 0, 0, 0, 0, 0, 0);
    // Load-use alone, then branch + load-use.
    drive("ld_use", 0, 0, 0, 0, 1, 0);
    drive("br_ld_use", 0, 0, 0, 0, 1, 1);
    // Redirect with fetch outstanding, stale word returns later.
    drive("br_ifbusy", 0, 0, 1, 0, 0, 1);
    drive("if_wait", 0, 0, 1, 0, 0, 0);
    drive("if_wait", 0, 0, 1, 0, 0, 0);
    drive("stale_word", 0, 0, 0, 1, 0, 0);
    drive("fresh_word", 0, 0, 0, 1, 0, 0);
    // Branch during a 2-cycle memory wait.
    drive("br_in_wait", 1, 0, 0, 0, 0, 1);
    drive("br_in_wait", 0, 0, 0, 0, 0, 1);
    drive("br_at_done", 0, 1, 0, 0, 0, 1);
    drive("after_done", 0, 0, 0, 0, 0, 0);

    // Timeout: 12 cycles with no dm_done, then completion; error stays.
    for (int i = 0; i < 12; i++) drive("timeout", 1, 0, 0, 0, 0, 0);
    drive("timeout_done", 0, 1, 0, 0, 0, 0);
    drive("err_sticky", 0, 0, 0, 0, 0, 0);
    // Reset in the middle of a wait with the error set.
    for (int i = 0; i < 10; i++) drive("wait_again", 1, 0, 0, 0, 0, 0);
    do_reset("async_reset_mid_wait");
    drive("post_reset", 0, 0, 0, 0, 0, 0);

    // Randomised traffic, periodically reset.
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) do_reset("rand_reset");
      drive("random", $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15);
    end
    drive("tail", 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
